// File: rtl/frogger_pkg.sv
// Shared types and keycode constants for the Frogger keyboard command path.
// Maps a single USB HID keycode to a discrete move command.
package frogger_pkg;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_UP    = 3'd1,
      CMD_DOWN  = 3'd2,
      CMD_LEFT  = 3'd3,
      CMD_RIGHT = 3'd4,
      CMD_PAUSE = 3'd5
   } cmd_t;

   localparam logic [7:0] KC_W     = 8'h1A;
   localparam logic [7:0] KC_A     = 8'h04;
   localparam logic [7:0] KC_S     = 8'h16;
   localparam logic [7:0] KC_D     = 8'h07;
   localparam logic [7:0] KC_UP    = 8'h52;
   localparam logic [7:0] KC_DOWN  = 8'h51;
   localparam logic [7:0] KC_LEFT  = 8'h50;
   localparam logic [7:0] KC_RIGHT = 8'h4F;
   localparam logic [7:0] KC_SPACE = 8'h2C;

   function automatic cmd_t decode_key(input logic [7:0] kc);
      cmd_t c;
      case (kc)
         KC_W, KC_UP:    c = CMD_UP;
         KC_S, KC_DOWN:  c = CMD_DOWN;
         KC_A, KC_LEFT:  c = CMD_LEFT;
         KC_D, KC_RIGHT: c = CMD_RIGHT;
         KC_SPACE:       c = CMD_PAUSE;
         default:        c = CMD_NONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/frogger_key_cmd_queue_cmd_fifo.sv
// First-word-fall-through command FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 3
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];
   assign count   = cnt;

   always_ff @(posedge Clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/frogger_key_cmd_queue.sv
// Turns the per-frame USB keycode word into a queue of hop commands with
// press detection and auto-repeat while a key stays held.
module frogger_key_cmd_queue
   import frogger_pkg::*;
#(
   parameter int unsigned N_SLOTS      = 2,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned REPEAT_DELAY = 20,
   parameter int unsigned REPEAT_RATE  = 6
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          frame_clk,
   input  logic [8*N_SLOTS-1:0]          keycode,
   input  logic                          cmd_ready,
   output logic                          cmd_valid,
   output logic [2:0]                    cmd_code,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [2:0]                    held_cmd
);

   localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT,
      ST_LATCHED
   } state_t;

   logic          fsync1, fsync2, fprev, tick;
   cmd_t          dec;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   cmd_t          held, held_n;
   logic          push, new_press;
   logic          pop, full, empty;
   logic [2:0]    fifo_dout;

   // Flops preset high so a frame_clk already high at reset release is not an edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fsync1 <= 1'b1;
         fsync2 <= 1'b1;
         fprev  <= 1'b1;
         tick   <= 1'b0;
      end else begin
         fsync1 <= frame_clk;
         fsync2 <= fsync1;
         fprev  <= fsync2;
         tick   <= fsync2 & ~fprev;
      end
   end

   always_comb begin
      dec = CMD_NONE;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (dec == CMD_NONE) dec = decode_key(keycode[8*i +: 8]);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         held  <= CMD_NONE;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         held  <= held_n;
      end
   end

   // A changed key in any held state restarts as a fresh press from IDLE.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      held_n    = held;
      push      = 1'b0;
      new_press = 1'b0;
      if (tick) begin
         held_n = dec;
         case (state)
            ST_IDLE: new_press = 1'b1;
            ST_DELAY, ST_REPEAT: begin
               if (dec == CMD_NONE) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else if (dec != held) begin
                  new_press = 1'b1;
               end else if (cnt == CW'(1)) begin
                  push    = 1'b1;
                  cnt_n   = CW'(REPEAT_RATE);
                  state_n = ST_REPEAT;
               end else begin
                  cnt_n = cnt - CW'(1);
               end
            end
            ST_LATCHED: begin
               if (dec == CMD_NONE) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else if (dec != CMD_PAUSE) begin
                  new_press = 1'b1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
         if (new_press) begin
            case (dec)
               CMD_NONE: begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end
               CMD_PAUSE: begin
                  push    = 1'b1;
                  state_n = ST_LATCHED;
               end
               default: begin
                  push    = 1'b1;
                  cnt_n   = CW'(REPEAT_DELAY);
                  state_n = ST_DELAY;
               end
            endcase
         end
      end
   end

   assign cmd_valid = ~empty;
   assign pop       = cmd_valid & cmd_ready;
   assign cmd_code  = cmd_valid ? fifo_dout : '0;
   assign held_cmd  = held;

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (3)
   ) u_fifo (
      .Clk   (Clk),
      .Reset (Reset),
      .push  (push),
      .din   (dec),
      .pop   (pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge Clk) begin
      if (Reset)                     overflow <= 1'b0;
      else if (push & full & ~pop)   overflow <= 1'b1;
   end

endmodule

// File: tb/tb_frogger_key_cmd_queue.sv
// Directed bench for frogger_key_cmd_queue: press timing, auto-repeat, slot
// priority, pause latching, overflow, full push/pop and reset mid-hold.
module tb_frogger_key_cmd_queue;
   import frogger_pkg::*;

   logic        Clk;
   logic        Reset;
   logic        frame_clk;
   logic [15:0] keycode;
   logic        cmd_ready;
   logic        cmd_valid;
   logic [2:0]  cmd_code;
   logic [2:0]  fifo_count;
   logic        overflow;
   logic [2:0]  held_cmd;

   int checks = 0;
   int errors = 0;

   logic [2:0] log_q[$];
   logic [2:0] exp_q[$];

   frogger_key_cmd_queue #(
      .N_SLOTS      (2),
      .FIFO_DEPTH   (4),
      .REPEAT_DELAY (20),
      .REPEAT_RATE  (6)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .keycode    (keycode),
      .cmd_ready  (cmd_ready),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .held_cmd   (held_cmd)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   // Record every accepted command, sampled mid-way between edges.
   always begin
      @(negedge Clk);
      #5;
      if (!Reset && cmd_valid && cmd_ready) log_q.push_back(cmd_code);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_log(input string tag);
      chk({tag, "_n"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
   endtask

   // One frame: VS high 6 cycles, low 4; optional ready pulse on the push cycle.
   task automatic do_frame(input logic [15:0] kc, input bit rdy_pulse);
      keycode   = kc;
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      if (rdy_pulse) cmd_ready = 1'b1;
      @(negedge Clk);
      if (rdy_pulse) cmd_ready = 1'b0;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   initial begin
      Reset     = 1'b1;
      frame_clk = 1'b0;
      keycode   = '0;
      cmd_ready = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_code", cmd_code, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_held", held_cmd, 0);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);

      // Single press: push on the 4th edge from the one that first sees VS high
      cmd_ready = 1'b1;
      keycode   = 16'h001A;
      frame_clk = 1'b1;
      @(negedge Clk); chk("sp_valid_e1", cmd_valid, 0);
      @(negedge Clk); chk("sp_valid_e2", cmd_valid, 0);
      @(negedge Clk); chk("sp_valid_e3", cmd_valid, 0);
      @(negedge Clk);
      chk("sp_valid_e4", cmd_valid, 1);
      chk("sp_code_e4", cmd_code, CMD_UP);
      chk("sp_held", held_cmd, CMD_UP);
      @(negedge Clk); chk("sp_valid_e5", cmd_valid, 0);
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      do_frame(16'h0000, 0);
      exp_q = '{CMD_UP};
      chk_log("sp_log");
      chk("sp_held_rel", held_cmd, CMD_NONE);
      chk("sp_ovf", overflow, 0);

      // Auto-repeat: pushes at frames 0, 20, 26, 32, 38
      log_q.delete();
      for (int f = 0; f < 40; f++) begin
         do_frame(16'h0050, 0);
         chk($sformatf("ar_held_%0d", f), held_cmd, CMD_LEFT);
      end
      exp_q = '{CMD_LEFT, CMD_LEFT, CMD_LEFT, CMD_LEFT, CMD_LEFT};
      chk_log("ar_log");
      do_frame(16'h0000, 0);

      // Slot priority, then change of key restarts the delay
      log_q.delete();
      do_frame(16'h4F51, 0);
      chk("pr_held0", held_cmd, CMD_DOWN);
      do_frame(16'h4F00, 0);
      chk("pr_held1", held_cmd, CMD_RIGHT);
      exp_q = '{CMD_DOWN, CMD_RIGHT};
      chk_log("pr_log1");
      repeat (19) do_frame(16'h4F00, 0);
      chk("pr_norep", log_q.size(), 2);
      do_frame(16'h4F00, 0);
      exp_q = '{CMD_DOWN, CMD_RIGHT, CMD_RIGHT};
      chk_log("pr_log2");
      do_frame(16'h0000, 0);

      // Pause does not repeat; release and re-press gives a second one
      log_q.delete();
      repeat (30) do_frame(16'h002C, 0);
      exp_q = '{CMD_PAUSE};
      chk_log("pa_log1");
      chk("pa_held", held_cmd, CMD_PAUSE);
      do_frame(16'h0000, 0);
      chk("pa_held_rel", held_cmd, CMD_NONE);
      do_frame(16'h002C, 0);
      exp_q = '{CMD_PAUSE, CMD_PAUSE};
      chk_log("pa_log2");
      do_frame(16'h0000, 0);

      // Overflow with consumer stalled
      cmd_ready = 1'b0;
      log_q.delete();
      do_frame(16'h001A, 0);
      do_frame(16'h0016, 0);
      do_frame(16'h0004, 0);
      do_frame(16'h0007, 0);
      chk("of_ovf_before", overflow, 0);
      do_frame(16'h0052, 0);
      chk("of_count", fifo_count, 4);
      chk("of_ovf", overflow, 1);
      chk("of_valid", cmd_valid, 1);
      chk("of_head", cmd_code, CMD_UP);
      do_frame(16'h0000, 0);
      cmd_ready = 1'b1;
      repeat (5) @(negedge Clk);
      cmd_ready = 1'b0;
      exp_q = '{CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};
      chk_log("of_log");
      chk("of_count_drained", fifo_count, 0);
      chk("of_ovf_sticky", overflow, 1);
      chk("of_code_empty", cmd_code, 0);

      // Full FIFO with push and pop in the same cycle
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);
      chk("fp_ovf_rst", overflow, 0);
      do_frame(16'h001A, 0);
      do_frame(16'h0016, 0);
      do_frame(16'h0004, 0);
      do_frame(16'h0007, 0);
      chk("fp_count_full", fifo_count, 4);
      log_q.delete();
      do_frame(16'h0050, 1);
      chk("fp_count", fifo_count, 4);
      chk("fp_ovf", overflow, 0);
      chk("fp_head", cmd_code, CMD_DOWN);
      chk("fp_held", held_cmd, CMD_LEFT);
      cmd_ready = 1'b1;
      repeat (5) @(negedge Clk);
      exp_q = '{CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_LEFT};
      chk_log("fp_log");
      chk("fp_count_drained", fifo_count, 0);

      // Reset while LEFT is held in DELAY, released with VS high
      Reset     = 1'b1;
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      chk("rm_valid", cmd_valid, 0);
      chk("rm_code", cmd_code, 0);
      chk("rm_count", fifo_count, 0);
      chk("rm_ovf", overflow, 0);
      chk("rm_held", held_cmd, 0);
      log_q.delete();
      Reset = 1'b0;
      repeat (6) @(negedge Clk);
      chk("rm_notick_log", log_q.size(), 0);
      chk("rm_notick_held", held_cmd, 0);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      do_frame(16'h0050, 0);
      exp_q = '{CMD_LEFT};
      chk_log("rm_log");
      chk("rm_held_after", held_cmd, CMD_LEFT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frogger_key_cmd_queue.md
Name: frogger_key_cmd_queue

Overview:
- Parametrised successor to the single-keycode movement handler: converts the NIOS-exported USB keycode word into a queue of discrete move commands for the game logic.
- Samples once per video frame, decodes N_SLOTS simultaneous keycodes with fixed priority, and generates press events plus auto-repeat while a key is held.
- Buffers commands in a FIFO with a valid/ready handshake, so frog hops are never lost or double-applied.
- Sits between the nios_system keycode export and the frogger game FSM; frame_clk is driven from VGA_VS.

Parameters:
- N_SLOTS, 2, number of 8-bit keycode slots in the keycode word (1..6).
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two, >= 2.
- REPEAT_DELAY, 20, frames a key must be held before the first auto-repeat (>= 1).
- REPEAT_RATE, 6, frames between subsequent auto-repeats (>= 1).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  VGA_VS; asynchronous to Clk in phase, rising edge marks a frame.
- keycode  in  8*N_SLOTS  packed USB HID keycodes; slot i = bits [8i+7:8i].
- cmd_ready  in  1  consumer accepts the head command this cycle.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  3  head command (cmd_t).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a command was dropped because the FIFO was full.
- held_cmd  out  3  command currently considered held (cmd_t), for debug and HEX display.

Behaviour:
- Clock and reset: one clock (Clk); Reset is synchronous, active-high.
- Reset values: all outputs 0 (cmd_t NONE); FIFO empty; FSM IDLE; counter 0. The frame_clk synchronizer flops and the previous-value flop reset to 1, so a high frame_clk at reset release produces no tick.
- Frame tick: frame_clk passes through a 2-FF synchronizer. tick = sync & ~prev, registered. The push occurs on the 4th Clk rising edge after the first edge that samples frame_clk high. cmd_valid (empty FIFO) is high after that edge.
- Decode, on tick only; keycode is sampled in that cycle:
  - UP: 0x1A (W) or 0x52.
  - DOWN: 0x16 (S) or 0x51.
  - LEFT: 0x04 (A) or 0x50.
  - RIGHT: 0x07 (D) or 0x4F.
  - PAUSE: 0x2C.
  - Anything else maps to NONE.
  - Lowest-index slot with a non-NONE decode wins.
- cmd_t encoding: NONE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, PAUSE=5.
- FSM, evaluated on tick only; d = decoded cmd:
  - IDLE: d=NONE, stay. d=PAUSE, push, go LATCHED. Otherwise push, cnt=REPEAT_DELAY, go DELAY.
  - DELAY / REPEAT: d=NONE, go IDLE. d != held_cmd, handle as from IDLE (new press, immediate push). d==held_cmd: if cnt==1, push, cnt=REPEAT_RATE, go REPEAT; else cnt-1.
  - LATCHED: PAUSE never repeats. d=NONE, go IDLE. d=PAUSE, stay. Other d, handle as from IDLE.
  - held_cmd = d after every tick; it is NONE in IDLE.
- Repeat timing: a held key pushes at frame 0, REPEAT_DELAY, REPEAT_DELAY+REPEAT_RATE, and every REPEAT_RATE frames after.
- Counter width: $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
- FIFO: first-word-fall-through.
  - cmd_code = head whenever cmd_valid, 0 otherwise.
  - pop = cmd_valid & cmd_ready; cmd_ready while empty is ignored.
  - Push and pop in the same cycle: both execute, count unchanged. This holds when full as well, so no drop occurs.
  - Push while full with no pop: the command is dropped, overflow sets, and overflow stays set until Reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: a held key is forgotten. After reset the key, if still held, is treated as a new press at the next tick.
- At most one push per tick, so FIFO_DEPTH >= 2 can absorb one frame of consumer stall.

Decomposition:
- frogger_pkg holds:
  - typedef enum logic [2:0] cmd_t.
  - Keycode localparams: KC_W, KC_A, KC_S, KC_D, KC_UP, KC_DOWN, KC_LEFT, KC_RIGHT, KC_SPACE.
  - Function decode_key(logic [7:0]) returning cmd_t.
- Sub-module cmd_fifo:
  - Parametrised by DEPTH and WIDTH=3.
  - Ports: push, din, pop, dout, count, full, empty.
  - Same Clk and synchronous Reset.
- Top level: synchronizer, edge detect, slot priority decode, FSM and counter.

Test Plan:
- Single press: keycode=0x001A held for 1 frame then 0, cmd_ready=1 -> exactly one UP. cmd_valid high 4 Clk after VS rise, for 1 cycle. overflow=0.
- Auto-repeat: hold 0x0050 for 40 frames with defaults, ready=1 -> LEFT pushed at frames 0, 20, 26, 32, 38 (5 commands). held_cmd=3 throughout.
- Slot priority and change: keycode=0x4F51 -> DOWN (slot0). Next frame 0x4F00 -> RIGHT immediate push. FSM moves to DELAY with a fresh count.
- Pause no-repeat: hold 0x002C for 30 frames -> exactly one PAUSE. Release, then press again -> second PAUSE.
- Overflow: cmd_ready=0, FIFO_DEPTH=4, 5 distinct presses on consecutive frames -> count=4, overflow=1. Pop order UP, DOWN, LEFT, RIGHT, 5th dropped. overflow stays 1 until Reset.
- Full with simultaneous push/pop, plus reset mid-hold:
  - FIFO full; cmd_ready=1 in the push cycle -> count stays 4, overflow=0.
  - Assert Reset while a key is held in DELAY -> all outputs 0.
  - First tick after release pushes the held key immediately.
  - A high VS at release generates no tick.
